// File: rtl/io_uart_fifo.sv
// Memory-mapped UART transmitter with a TX FIFO: DATA writes queue bytes, STATUS
// reads report FIFO/FSM state, and an 8N1 serialiser drains the FIFO on uart_tx.
`timescale 1ns/1ps
module io_uart_fifo #(
    parameter int CLK_DIV = 10,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_wr,
    output logic [31:0] io_rdata,
    output logic        uart_tx
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [DEPTH];

    logic data_sel, status_sel, full, empty, push, pop, baud_tc;
    logic unused_ok;

    assign data_sel   = io_addr[22] & io_addr[3];
    assign status_sel = io_addr[22] & io_addr[4];
    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    // Fullness is judged before this cycle's pop, so a write racing a pop while full is lost.
    assign push       = io_wr & data_sel & ~full;
    assign pop        = (state_q == ST_IDLE) & ~empty;
    assign baud_tc    = (baud_q == BAUD_LAST);
    assign unused_ok  = ^{io_addr[31:23], io_addr[21:5], io_addr[2:0], io_wdata[31:8]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q] <= io_wdata[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        if (io_wr && status_sel) begin
            ovf_d = 1'b0;
        end else if (io_wr && data_sel && full) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_tx  = 1'b1;
        io_rdata = '0;
        case (state_q)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = shift_q[0];
            default:  uart_tx = 1'b1;
        endcase
        if (status_sel) begin
            io_rdata[7:0] = 8'(count_q);
            io_rdata[9]   = full;
            io_rdata[10]  = empty;
            io_rdata[11]  = (state_q != ST_IDLE);
            io_rdata[12]  = ovf_q;
        end
    end
endmodule

// File: tb/tb_io_uart_fifo.sv
// Bench for io_uart_fifo: register vector table plus frame-level scoreboard that
// decodes uart_tx cycle by cycle and compares bytes against what was queued.
`timescale 1ns/1ps
module tb_io_uart_fifo;
    localparam int CLK_DIV = 10;
    localparam int DEPTH   = 8;
    localparam int FB      = 10 * CLK_DIV;
    localparam logic [31:0] A_DATA    = 32'h0040_0008;
    localparam logic [31:0] A_STAT    = 32'h0040_0010;
    localparam logic [31:0] A_BOTH    = 32'h0040_0018;
    localparam logic [31:0] A_UNDEC   = 32'h0000_0010;
    localparam logic [31:0] A_UNDEC_D = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic        io_wr = 1'b0;
    logic [31:0] io_rdata;
    logic        uart_tx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];
    bit         mon_busy = 1'b0;
    logic [FB-1:0] samp;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    bit         aborted, shape_ok;
    int         slot;
    logic       nb;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        exp_push;
        logic [31:0] exp_rdata;
        logic        exp_tx;
    } vec_t;
    vec_t vecs[11];

    io_uart_fifo #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_wr(io_wr), .io_rdata(io_rdata), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_addr = a; io_wdata = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0; io_addr = '0; io_wdata = '0;
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit accept);
        if (accept) exp_q.push_back(b);
        wr(A_DATA, {24'h0, b});
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        io_addr = a;
        #1;
        check(name, io_rdata, exp);
        io_addr = '0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic get_start(input string name, input int idx, output int s);
        vectors++;
        if (starts_q.size() > idx) begin
            s = starts_q[idx];
        end else begin
            miscompares++;
            $display("FAIL %s: got %0d frame starts, required %0d", name, starts_q.size(), idx + 1);
            s = cyc;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Line monitor: every cycle of a frame must match the nominal 8N1 waveform.
    always begin
        @(negedge clk); #2;
        if (resetn === 1'b1 && uart_tx === 1'b0) begin
            mon_busy = 1'b1;
            starts_q.push_back(cyc);
            samp = '0;
            aborted = 1'b0;
            for (int i = 1; i < FB; i++) begin
                @(negedge clk); #2;
                if (resetn !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                samp[i] = uart_tx;
            end
            if (!aborted) begin
                for (int k = 0; k < 8; k++) rx_byte[k] = samp[(k + 1) * CLK_DIV + CLK_DIV / 2];
                shape_ok = 1'b1;
                for (int i = 0; i < FB; i++) begin
                    slot = i / CLK_DIV;
                    nb = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : rx_byte[slot - 1];
                    if (samp[i] !== nb) shape_ok = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_unexpected: got byte 0x%02h at cycle %0d, required no frame", rx_byte, starts_q[$]);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("frame_{shape,byte}", {23'b0, shape_ok, rx_byte}, {23'b0, 1'b1, exp_byte});
                end
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1);
    end

    initial begin
        int n0, s0, s1, s2, nstart;
        vecs[0]  = '{A_STAT,    32'h0,         1'b0, 1'b0, 32'h400, 1'b1};
        vecs[1]  = '{A_UNDEC,   32'h0,         1'b0, 1'b0, 32'h0,   1'b1};
        vecs[2]  = '{A_DATA,    32'h0,         1'b0, 1'b0, 32'h0,   1'b1};
        vecs[3]  = '{A_BOTH,    32'h0,         1'b0, 1'b0, 32'h400, 1'b1};
        vecs[4]  = '{A_UNDEC_D, 32'hAA,        1'b1, 1'b0, 32'h0,   1'b1};
        vecs[5]  = '{A_STAT,    32'hFFFF_FFFF, 1'b1, 1'b0, 32'h400, 1'b1};
        vecs[6]  = '{A_STAT,    32'h0,         1'b0, 1'b0, 32'h400, 1'b1};
        vecs[7]  = '{A_DATA,    32'h155,       1'b1, 1'b1, 32'h0,   1'b1};
        vecs[8]  = '{A_STAT,    32'h0,         1'b0, 1'b0, 32'h001, 1'b1};
        vecs[9]  = '{A_STAT,    32'h0,         1'b0, 1'b0, 32'hC00, 1'b0};
        vecs[10] = '{A_STAT,    32'h0,         1'b0, 1'b0, 32'hC00, 1'b0};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_tx", 32'(uart_tx), 32'h1);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            io_addr = vecs[i].addr; io_wdata = vecs[i].wdata; io_wr = vecs[i].wr;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].wdata[7:0]);
            #1;
            check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_tx", i), 32'(uart_tx), 32'(vecs[i].exp_tx));
            @(negedge clk);
        end
        io_wr = 1'b0; io_addr = '0; io_wdata = '0;
        repeat (40) @(negedge clk);
        rd("mid_frame_status", A_STAT, 32'hC00);
        drain("byte55");
        rd("idle_status", A_STAT, 32'h400);

        // Three back-to-back bytes: one idle cycle between frames.
        n0 = starts_q.size();
        wr_byte(8'h41, 1'b1); wr_byte(8'h42, 1'b1); wr_byte(8'h43, 1'b1);
        rd("abc_count2", A_STAT, 32'h802);
        drain("abc");
        get_start("abc_start0", n0, s0);
        get_start("abc_start1", n0 + 1, s1);
        get_start("abc_start2", n0 + 2, s2);
        check("abc_gap1", s1 - s0, FB + 1);
        check("abc_gap2", s2 - s1, FB + 1);

        // Overflow while a frame is on the line.
        n0 = starts_q.size();
        wr_byte(8'h30, 1'b1);
        @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) wr_byte(8'(8'h31 + i), i < DEPTH);
        rd("ovf_status", A_STAT, 32'h1A08);
        rd("busy_undecoded", A_UNDEC, 32'h0);
        rd("busy_data_addr", A_DATA, 32'h0);
        wr(A_STAT, 32'h0);
        rd("ovf_cleared", A_STAT, 32'h0A08);
        wr(A_BOTH, 32'h99);
        rd("clear_beats_set", A_STAT, 32'h0A08);
        get_start("ovf_start0", n0, s0);
        wait_cyc(s0 + FB);
        wr(A_DATA, 32'hEE);
        rd("pop_edge_drop", A_STAT, 32'h1807);
        wr(A_STAT, 32'h0);
        rd("pop_edge_clear", A_STAT, 32'h0807);
        drain("ovf");

        // Reset during data bit 4 with three bytes queued.
        n0 = starts_q.size();
        wr_byte(8'h2F, 1'b0); wr_byte(8'h51, 1'b0); wr_byte(8'h52, 1'b0); wr_byte(8'h53, 1'b0);
        rd("rst_pre_status", A_STAT, 32'h0803);
        get_start("rst_start", n0, s0);
        wait_cyc(s0 + 5 * CLK_DIV + 5);
        #1 check("rst_pre_tx", 32'(uart_tx), 32'h0);
        resetn = 1'b0; io_addr = A_DATA; io_wdata = 32'h77; io_wr = 1'b1;
        @(negedge clk);
        #1 check("rst_abort_tx", 32'(uart_tx), 32'h1);
        io_wr = 1'b0;
        rd("rst_status", A_STAT, 32'h400);
        io_addr = A_DATA; io_wdata = 32'h78; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0; io_addr = '0; io_wdata = '0; resetn = 1'b1;
        rd("rst_wr_ignored", A_STAT, 32'h400);
        nstart = starts_q.size();
        repeat (300) @(negedge clk);
        check("rst_no_frames", starts_q.size(), nstart);
        rd("rst_final_status", A_STAT, 32'h400);
        check("rst_final_tx", 32'(uart_tx), 32'h1);

        // Push coinciding with the pop of the last queued byte.
        n0 = starts_q.size();
        wr_byte(8'h61, 1'b1); wr_byte(8'h62, 1'b1);
        @(negedge clk);
        get_start("pp_start0", n0, s0);
        wait_cyc(s0 + FB);
        wr_byte(8'h63, 1'b1);
        rd("pp_count1", A_STAT, 32'h801);
        drain("pushpop");
        get_start("pp_start1", n0 + 1, s1);
        get_start("pp_start2", n0 + 2, s2);
        check("pp_gap", s2 - s1, FB + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/io_uart_fifo.md
IO_UART_FIFO -- requirements
Module: io_uart_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10, clk cycles per UART bit (minimum 2).
REQ-002 SHALL have parameter DEPTH, default 8, TX FIFO entries (power of 2, minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port io_addr  input  32  core IO byte address.
REQ-006 SHALL have port io_wdata  input  32  core IO write data.
REQ-007 SHALL have port io_wr  input  1  core IO write strobe, single cycle per store.
REQ-008 SHALL have port io_rdata  output  32  IO read data, combinational from io_addr.
REQ-009 SHALL have port uart_tx  output  1  serial line, 8N1, idle high.

Function
REQ-010 SHALL decode DATA register as io_addr[22]=1 and io_addr[3]=1 (word address bit 1), and STATUS register as io_addr[22]=1 and io_addr[4]=1 (word address bit 2).
REQ-011 SHALL push io_wdata[7:0] into FIFO on a cycle with io_wr=1, DATA selected, FIFO not full.
REQ-012 SHALL drop a DATA write while FIFO is full, even when a pop occurs in the same cycle, and set sticky flag ovf.
REQ-013 SHALL clear ovf on any io_wr with STATUS selected; clear has priority over a simultaneous set.
REQ-014 SHALL drive io_rdata, when STATUS selected: bit9=full, bit10=empty, bit11=tx_busy (FSM not IDLE), bit12=ovf, bits[7:0]=FIFO count; all other bits 0.
REQ-015 SHALL drive io_rdata=0 when STATUS not selected.
REQ-016 SHALL implement FIFO with read/write pointers wrapping modulo DEPTH and count 0..DEPTH; full = count==DEPTH, empty = count==0.
REQ-017 SHALL allow push and pop in the same cycle when not full: count unchanged, order preserved.
REQ-018 SHALL implement TX FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: uart_tx=1; if FIFO non-empty, pop head into shift register, clear bit counter and baud counter, go START.
REQ-020 START: uart_tx=0 for CLK_DIV cycles, then DATA.
REQ-021 DATA: uart_tx=shift[0]; every CLK_DIV cycles shift right and increment bit counter; after 8 bits go STOP.
REQ-022 STOP: uart_tx=1 for CLK_DIV cycles, then IDLE.
REQ-023 Frame occupies exactly 10*CLK_DIV cycles from START entry to IDLE re-entry; back-to-back frames SHALL have exactly one IDLE cycle between STOP and next START.
REQ-024 Latency: DATA write captured at edge N with FIFO empty and FSM IDLE -> pop at edge N+1, uart_tx=0 from edge N+1 onward.
REQ-025 Baud counter SHALL count 0..CLK_DIV-1 and wrap; bit boundary on terminal count.
REQ-026 FIFO contents SHALL NOT be altered by STATUS reads; reads have no side effects.

Reset
REQ-027 On resetn=0 at a clock edge: FSM=IDLE, uart_tx=1, pointers=0, count=0, ovf=0, baud and bit counters=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately (uart_tx=1 after the edge) and discard all queued bytes.
REQ-029 io_wr during reset cycles SHALL be ignored.
REQ-030 FIFO storage array needs no reset; status after reset SHALL read 0x400 (empty only).

Verification
REQ-031 Write 0x55 to DATA at idle, CLK_DIV=10 -> uart_tx low 10 cycles from next edge, then bits 1,0,1,0,1,0,1,0 each 10 cycles, high 10 cycles; status bit11=1 during 100-cycle frame.
REQ-032 Write 0x41,0x42,0x43 in consecutive cycles -> three frames in order, each 100 cycles, one idle cycle between; count reads 2 after first pop.
REQ-033 Write DEPTH+2 bytes back-to-back while frame in progress -> full=1, ovf=1, extra bytes lost, remaining DEPTH bytes transmitted in order; STATUS write clears ovf to 0.
REQ-034 Assert resetn=0 during DATA bit 4 with 3 bytes queued -> uart_tx=1 next cycle, status reads 0x400, no further frames.
REQ-035 Read STATUS and non-decoded addresses (io_addr[22]=0) while busy -> STATUS reflects count/busy, other addresses return 0, FIFO unaffected.
REQ-036 Push and pop same cycle at count=1 with FSM entering IDLE -> count stays 1, new byte transmitted next.
